// File: rtl/mips_pkg.sv
// Shared types and constants for the pipelined MIPS core.
package mips_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES   = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// Branch/jump target construction and next-PC priority select for the fetch stage.
module next_pc_mux
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             redirectEn,
    input  logic             stall,
    input  logic             branchTaken,
    input  logic [WIDTH-1:0] branchOffset,
    input  logic [WIDTH-1:0] branchBasePC,
    input  logic             jump,
    input  logic [25:0]      jumpIndex,
    output logic [WIDTH-1:0] seqPC,
    output logic             redirect,
    output logic [WIDTH-1:0] nextPC
);

    logic [WIDTH-1:0] brTgt;
    logic [WIDTH-1:0] jTgt;
    logic [WIDTH-1:0] selPC;

    assign seqPC    = pc + WIDTH'(INSTR_BYTES);
    assign brTgt    = branchBasePC + branchOffset;
    assign jTgt     = {branchBasePC[WIDTH-1:28], jumpIndex, 2'b00};
    assign redirect = redirectEn & (jump | branchTaken);

    // Redirects outrank the stall hold; jump outranks branch.
    always_comb begin
        selPC = seqPC;
        if (redirectEn && jump) begin
            selPC = jTgt;
        end else if (redirectEn && branchTaken) begin
            selPC = brTgt;
        end else if (stall) begin
            selPC = pc;
        end
    end

    assign nextPC = {selPC[WIDTH-1:2], 2'b00};

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator and IF/ID pipeline register with stall, flush and redirect counting.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branchTaken,
    input  logic [WIDTH-1:0] branchOffset,
    input  logic [WIDTH-1:0] branchBasePC,
    input  logic             jump,
    input  logic [25:0]      jumpIndex,
    input  logic [31:0]      instrIn,
    output logic [WIDTH-1:0] pcOut,
    output logic [WIDTH-1:0] ifidPC4,
    output logic [31:0]      ifidInstr,
    output logic             ifidValid,
    output logic [CNT_W-1:0] flushCount
);

    fetch_state_t     stateQ, stateD;
    logic [WIDTH-1:0] pcQ, pcD;
    logic [WIDTH-1:0] pc4Q, pc4D;
    logic [31:0]      instrQ, instrD;
    logic             validQ, validD;
    logic [CNT_W-1:0] cntQ, cntD;

    logic             redirectEn;
    logic             redirect;
    logic [WIDTH-1:0] seqPC;
    logic [WIDTH-1:0] nextPC;

    // Only RUN may redirect: in BOOT and FLUSH the ID stage holds a NOP.
    assign redirectEn = (stateQ == RUN);

    next_pc_mux #(
        .WIDTH(WIDTH)
    ) uNextPcMux (
        .pc          (pcQ),
        .redirectEn  (redirectEn),
        .stall       (stall),
        .branchTaken (branchTaken),
        .branchOffset(branchOffset),
        .branchBasePC(branchBasePC),
        .jump        (jump),
        .jumpIndex   (jumpIndex),
        .seqPC       (seqPC),
        .redirect    (redirect),
        .nextPC      (nextPC)
    );

    always_comb begin
        stateD = stateQ;
        pcD    = pcQ;
        pc4D   = pc4Q;
        instrD = instrQ;
        validD = validQ;
        cntD   = cntQ;
        case (stateQ)
            BOOT: begin
                pcD    = nextPC;
                instrD = NOP_INSTR;
                validD = 1'b0;
                stateD = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pcD    = nextPC;
                    instrD = NOP_INSTR;
                    validD = 1'b0;
                    if (cntQ != {CNT_W{1'b1}}) begin
                        cntD = cntQ + 1'b1;
                    end
                    stateD = FLUSH;
                end else if (!stall) begin
                    pcD    = nextPC;
                    pc4D   = seqPC;
                    instrD = instrIn;
                    validD = 1'b1;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    pcD    = nextPC;
                    pc4D   = seqPC;
                    instrD = instrIn;
                    validD = 1'b1;
                    stateD = RUN;
                end
            end
            default: stateD = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= BOOT;
            pcQ    <= {RESET_PC[WIDTH-1:2], 2'b00};
            pc4Q   <= '0;
            instrQ <= NOP_INSTR;
            validQ <= 1'b0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            pcQ    <= pcD;
            pc4Q   <= pc4D;
            instrQ <= instrD;
            validQ <= validD;
            cntQ   <= cntD;
        end
    end

    assign pcOut      = pcQ;
    assign ifidPC4    = pc4Q;
    assign ifidInstr  = instrQ;
    assign ifidValid  = validQ;
    assign flushCount = cntQ;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, redirects, stalls, wrap, reset and saturation.
module tb_fetch_pc_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             branchTaken;
    logic [WIDTH-1:0] branchOffset;
    logic [WIDTH-1:0] branchBasePC;
    logic             jump;
    logic [25:0]      jumpIndex;
    logic [31:0]      instrIn;
    logic [WIDTH-1:0] pcOut;
    logic [WIDTH-1:0] ifidPC4;
    logic [31:0]      ifidInstr;
    logic             ifidValid;
    logic [CNT_W-1:0] flushCount;

    int nTotal = 0;
    int nBad   = 0;

    always #5 clk = ~clk;

    // Instruction memory model: each word is its address plus a tag.
    assign instrIn = pcOut + 32'h1000_0000;

    fetch_pc_unit #(
        .WIDTH   (WIDTH),
        .RESET_PC(32'h0000_0000),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .branchTaken (branchTaken),
        .branchOffset(branchOffset),
        .branchBasePC(branchBasePC),
        .jump        (jump),
        .jumpIndex   (jumpIndex),
        .instrIn     (instrIn),
        .pcOut       (pcOut),
        .ifidPC4     (ifidPC4),
        .ifidInstr   (ifidInstr),
        .ifidValid   (ifidValid),
        .flushCount  (flushCount)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chkIfid(input string tag, input logic [31:0] pc4, input logic [31:0] ins,
                           input logic vld);
        chk({tag, ".pc4"}, ifidPC4, pc4);
        chk({tag, ".instr"}, ifidInstr, ins);
        chk({tag, ".valid"}, {31'b0, ifidValid}, {31'b0, vld});
    endtask

    task automatic clearCtl();
        stall        = 1'b0;
        branchTaken  = 1'b0;
        jump         = 1'b0;
        branchOffset = '0;
        branchBasePC = '0;
        jumpIndex    = '0;
    endtask

    initial begin
        reset = 1'b1;
        clearCtl();
        @(negedge clk);
        @(negedge clk);
        chk("rst.pc", pcOut, 32'h0);
        chkIfid("rst", 32'h0, 32'h0, 1'b0);
        chk("rst.cnt", 32'(flushCount), 32'h0);
        reset = 1'b0;

        // Sequential fetch: BOOT inserts a bubble, then IF/ID follows the PC.
        step();
        chk("seq1.pc", pcOut, 32'h4);
        chk("seq1.valid", {31'b0, ifidValid}, 32'h0);
        step();
        chk("seq2.pc", pcOut, 32'h8);
        chkIfid("seq2", 32'h8, 32'h1000_0004, 1'b1);
        step();
        chk("seq3.pc", pcOut, 32'hC);
        chkIfid("seq3", 32'hC, 32'h1000_0008, 1'b1);
        step();
        chk("seq4.pc", pcOut, 32'h10);
        chkIfid("seq4", 32'h10, 32'h1000_000C, 1'b1);

        // Backward branch to 0xFFFF_FFFC; branchTaken held into FLUSH must be ignored.
        branchTaken  = 1'b1;
        branchBasePC = 32'h0000_000C;
        branchOffset = 32'hFFFF_FFF0;
        step();
        chk("br.pc", pcOut, 32'hFFFF_FFFC);
        chkIfid("br", 32'h10, 32'h0, 1'b0);
        chk("br.cnt", 32'(flushCount), 32'h1);
        step();
        chk("wrap.pc", pcOut, 32'h0);
        chkIfid("wrap", 32'h0, 32'h0FFF_FFFC, 1'b1);
        chk("wrap.cnt", 32'(flushCount), 32'h1);
        clearCtl();
        step();
        chk("run.pc", pcOut, 32'h4);
        chkIfid("run", 32'h4, 32'h1000_0000, 1'b1);

        // Jump and branch together: jump wins, one flush counted.
        jump         = 1'b1;
        branchTaken  = 1'b1;
        branchBasePC = 32'h4000_0008;
        branchOffset = 32'h0000_0100;
        jumpIndex    = 26'h000_0100;
        step();
        chk("jb.pc", pcOut, 32'h4000_0400);
        chk("jb.valid", {31'b0, ifidValid}, 32'h0);
        chk("jb.cnt", 32'(flushCount), 32'h2);
        clearCtl();
        step();
        chk("jb2.pc", pcOut, 32'h4000_0404);
        chkIfid("jb2", 32'h4000_0404, 32'h5000_0400, 1'b1);

        // Jump to 0x1C so the stall window lands on pcOut=0x20.
        jump      = 1'b1;
        jumpIndex = 26'h000_0007;
        step();
        chk("j1c.pc", pcOut, 32'h1C);
        chk("j1c.cnt", 32'(flushCount), 32'h3);
        clearCtl();
        step();
        chk("j1c2.pc", pcOut, 32'h20);
        chkIfid("j1c2", 32'h20, 32'h1000_001C, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.pc", pcOut, 32'h20);
            chkIfid("stall", 32'h20, 32'h1000_001C, 1'b1);
        end
        // Redirect overrides stall; misaligned target gets its low bits cleared.
        branchTaken  = 1'b1;
        branchBasePC = 32'h0000_0101;
        branchOffset = 32'h0000_0020;
        step();
        chk("stbr.pc", pcOut, 32'h120);
        chk("stbr.valid", {31'b0, ifidValid}, 32'h0);
        chk("stbr.cnt", 32'(flushCount), 32'h4);
        clearCtl();

        // Asynchronous reset in the middle of FLUSH, away from any clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk("arst.pc", pcOut, 32'h0);
        chkIfid("arst", 32'h0, 32'h0, 1'b0);
        chk("arst.cnt", 32'(flushCount), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("arst2.pc", pcOut, 32'h4);

        // Saturate the flush counter and keep redirecting past the limit.
        for (int i = 1; i <= 17; i++) begin
            branchTaken  = 1'b1;
            branchOffset = 32'h0000_0040;
            step();
            branchTaken = 1'b0;
            step();
            if (i == 14) chk("sat14.cnt", 32'(flushCount), 32'd14);
            if (i == 15) chk("sat15.cnt", 32'(flushCount), 32'd15);
        end
        chk("sat17.cnt", 32'(flushCount), 32'd15);
        chk("sat17.pc", pcOut, 32'h44);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1);
    end

endmodule
